// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Purpose:
//   Sits downstream of aes_cipher_512. It captures each 512-bit ciphertext
//   block from a one-cycle strobe and stores it in a small block FIFO. Each
//   block is then sent out as four 128-bit beats on a valid/ready stream,
//   MSB lane first. The cipher cannot be stalled, so a block that arrives
//   while the buffer is full is dropped and flagged.
//
// Parameters:
//   DEPTH  number of 512-bit entries buffered (power of 2, >= 2)
//   LVL_W  width of fifo_level; must hold 0..DEPTH
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-low reset
//   in_valid    in   1      block strobe from the cipher
//   in_data     in   512    block data, sampled when in_valid=1
//   out_data    out  128    current beat (0 when out_valid=0)
//   out_valid   out  1      beat available
//   out_ready   in   1      consumer accepts the beat
//   out_last    out  1      final (4th) beat of a block
//   fifo_level  out  LVL_W  blocks held (whole or partially sent)
//   ovf         out  1      sticky drop flag
//   ovf_clr     in   1      synchronous clear of ovf (and drop_cnt)
//   drop_cnt    out  16     saturating dropped-block count
//                           (present only with AES_SER_DROP_CNT_EN)
//
// Configuration macro:
//   AES_SER_DROP_CNT_EN  adds the drop_cnt port and its counter
//
// Handshake: a beat transfers on any rising edge where out_valid and
//   out_ready are both 1. While out_valid=1 and out_ready=0, out_data and
//   out_last hold their values. The input side has no ready; in_valid is a
//   pure strobe and a block that cannot be stored is dropped.
// ---------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int DEPTH = 2,
    parameter int LVL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [511:0]     in_data,
    output logic [127:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [LVL_W-1:0] fifo_level,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef AES_SER_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [511:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [1:0]       beat;
    logic [LVL_W-1:0] level;

    logic             full;
    logic             xfer;
    logic             pop_final;
    logic             accept;
    logic             drop;
    logic [511:0]     cur;

    assign full      = (level == LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign xfer      = out_valid & out_ready;
    assign pop_final = xfer & (beat == 2'd3);
    // When full, a write can still be stored if the slot being read is freed
    // in this same cycle. With wr_ptr == rd_ptr the entry is overwritten at
    // the edge that retires it.
    assign accept    = in_valid & (~full | pop_final);
    assign drop      = in_valid & ~accept;

    assign fifo_level = level;
    assign out_last   = out_valid & (beat == 2'd3);

    // Pick the lane for the current beat, MSB lane first. The output is
    // forced to 0 when idle so stale storage never shows on the bus.
    always_comb begin
        cur      = mem[rd_ptr];
        out_data = '0;
        if (out_valid) begin
            case (beat)
                2'd0:    out_data = cur[511:384];
                2'd1:    out_data = cur[383:256];
                2'd2:    out_data = cur[255:128];
                default: out_data = cur[127:0];
            endcase
        end
    end

    // Storage has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            beat   <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (xfer) begin
                beat <= beat + 2'd1;   // wraps 3 -> 0 on the final beat
            end
            if (pop_final) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop_final})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, so the event is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef AES_SER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [511:0] in_data = '0;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic [1:0]   fifo_level;
    logic         ovf;
    logic         ovf_clr = 1'b0;
`ifdef AES_SER_DROP_CNT_EN
    logic [15:0]  drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    aes_out_serializer #(.DEPTH(2), .LVL_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef AES_SER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    // Lane k of a tagged block: tag in the top byte, lane index in the low byte.
    function automatic logic [127:0] lane(input logic [7:0] tag, input int k);
        lane = {tag, 112'h0, 8'(k)};
    endfunction

    function automatic logic [511:0] blk(input logic [7:0] tag);
        blk = {lane(tag, 0), lane(tag, 1), lane(tag, 2), lane(tag, 3)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = blk(8'hEE); out_ready = 1'b1;
        tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 128'h0) begin fails++; $display("FAIL reset_data got %h exp 0", out_data); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b exp 0", out_last); end
        tests++; if (fifo_level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`ifdef AES_SER_DROP_CNT_EN
        tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
`endif
        in_valid = 1'b0; rst = 1'b1;
        tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid got %b exp 0", out_valid); end
        tests++; if (fifo_level !== 2'd0) begin fails++; $display("FAIL post_reset_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_single();
        logic [127:0] e [4];
        e[0] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        e[1] = 128'h0; e[2] = 128'h0; e[3] = 128'h0;
        in_data = {128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 384'h0};
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid beat %0d got %b exp 1", b, out_valid); end
            tests++; if (out_data !== e[b]) begin fails++; $display("FAIL single_data beat %0d got %h exp %h", b, out_data, e[b]); end
            tests++; if (out_last !== (b == 3)) begin fails++; $display("FAIL single_last beat %0d got %b exp %b", b, out_last, (b == 3)); end
            tests++; if (fifo_level !== 2'd1) begin fails++; $display("FAIL single_level beat %0d got %0d exp 1", b, fifo_level); end
            tick();
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid got %b exp 0", out_valid); end
        tests++; if (fifo_level !== 2'd0) begin fails++; $display("FAIL single_end_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_backpressure();
        logic pat [7];
        int   b;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b0; in_data = blk(8'hB0); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        b = 0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc %0d got %b exp 1", i, out_valid); end
            tests++; if (out_data !== lane(8'hB0, b)) begin fails++; $display("FAIL bp_data cyc %0d got %h exp %h", i, out_data, lane(8'hB0, b)); end
            tests++; if (out_last !== (b == 3)) begin fails++; $display("FAIL bp_last cyc %0d got %b exp %b", i, out_last, (b == 3)); end
            tick();
            if (pat[i]) b++;
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_end_valid got %b exp 0", out_valid); end
        tests++; if (fifo_level !== 2'd0) begin fails++; $display("FAIL bp_end_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [7:0] tags [2];
        tags = '{8'hA1, 8'hB2};
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = blk(8'hA1); tick();
        in_data = blk(8'hB2); tick();
        in_data = blk(8'hC3); tick();
        in_valid = 1'b0;
        tests++; if (fifo_level !== 2'd2) begin fails++; $display("FAIL ovf_level got %0d exp 2", fifo_level); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", ovf); end
`ifdef AES_SER_DROP_CNT_EN
        tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL ovf_drop_cnt got %0d exp 1", drop_cnt); end
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) begin
                tests++; if (out_data !== lane(tags[k], b)) begin fails++; $display("FAIL ovf_drain blk %0d beat %0d got %h exp %h", k, b, out_data, lane(tags[k], b)); end
                tests++; if (out_last !== (b == 3)) begin fails++; $display("FAIL ovf_drain_last blk %0d beat %0d got %b exp %b", k, b, out_last, (b == 3)); end
                tick();
            end
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_no_c got valid %b exp 0", out_valid); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr got %b exp 0", ovf); end
`ifdef AES_SER_DROP_CNT_EN
        tests++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL ovf_clr_cnt got %0d exp 0", drop_cnt); end
`endif
    endtask

    task automatic test_full_pop();
        logic [7:0] tags [2];
        tags = '{8'hE5, 8'hF6};
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = blk(8'hD4); tick();
        in_data = blk(8'hE5); tick();
        in_valid = 1'b0;
        tests++; if (fifo_level !== 2'd2) begin fails++; $display("FAIL fp_level_full got %0d exp 2", fifo_level); end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tests++; if (out_data !== lane(8'hD4, b)) begin fails++; $display("FAIL fp_d beat %0d got %h exp %h", b, out_data, lane(8'hD4, b)); end
            tick();
        end
        tests++; if (out_last !== 1'b1) begin fails++; $display("FAIL fp_d_last got %b exp 1", out_last); end
        in_valid = 1'b1; in_data = blk(8'hF6);
        tick();
        in_valid = 1'b0;
        tests++; if (fifo_level !== 2'd2) begin fails++; $display("FAIL fp_level_keep got %0d exp 2", fifo_level); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fp_ovf got %b exp 0", ovf); end
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 4; b++) begin
                tests++; if (out_data !== lane(tags[k], b)) begin fails++; $display("FAIL fp_drain blk %0d beat %0d got %h exp %h", k, b, out_data, lane(tags[k], b)); end
                tick();
            end
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fp_end_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_clr_vs_drop();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = blk(8'h17); tick();
        in_data = blk(8'h28); tick();
        in_data = blk(8'h39); ovf_clr = 1'b1;
        tick();
        in_valid = 1'b0; ovf_clr = 1'b0;
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL clr_drop_ovf got %b exp 1", ovf); end
        tests++; if (fifo_level !== 2'd2) begin fails++; $display("FAIL clr_drop_level got %0d exp 2", fifo_level); end
`ifdef AES_SER_DROP_CNT_EN
        tests++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL clr_drop_cnt got %0d exp 1", drop_cnt); end
`endif
        rst = 1'b0; tick(); rst = 1'b1; tick();
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL clr_drop_rst_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; in_valid = 1'b1; in_data = blk(8'h4A);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        tests++; if (out_data !== lane(8'h4A, 2)) begin fails++; $display("FAIL mid_pre got %h exp %h", out_data, lane(8'h4A, 2)); end
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        tests++; if (fifo_level !== 2'd0) begin fails++; $display("FAIL mid_level got %0d exp 0", fifo_level); end
        tests++; if (out_data !== 128'h0) begin fails++; $display("FAIL mid_data got %h exp 0", out_data); end
        tick();
        rst = 1'b1;
        tick();
        in_valid = 1'b1; in_data = blk(8'h5B);
        tick();
        in_valid = 1'b0;
        tests++; if (out_data !== lane(8'h5B, 0)) begin fails++; $display("FAIL mid_restart_data got %h exp %h", out_data, lane(8'h5B, 0)); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL mid_restart_last got %b exp 0", out_last); end
        tests++; if (fifo_level !== 2'd1) begin fails++; $display("FAIL mid_restart_level got %0d exp 1", fifo_level); end
        tick(); tick(); tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_end_valid got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_clr_vs_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
